tinyqv_fetch_buffer: RTL and testbench

//  Parametrised instruction prefetch buffer between the QSPI instruction fetch path and the decoder.
//  - Holds a ring of 2**DEPTH_LOG2 halfwords.
//  - Presents the next whole RV32/RVC instruction at the PC and advances by its length on consume.
//  - Flushes and restarts fetch on redirect (branch, jump, return, interrupt).
//  - Generalises the fixed 4-halfword fetch queue: configurable depth, explicit fill level, overflow detection.

---
 rtl/tinyqv_fetch_pkg.sv | 19 +
 rtl/tinyqv_fetch_ring.sv | 54 +++++
 rtl/tinyqv_fetch_buffer.sv | 120 ++++++++++++
 tb/tb_tinyqv_fetch_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tinyqv_fetch_pkg.sv
// rtl/tinyqv_fetch_pkg.sv - shared types and helpers for the instruction prefetch buffer
package tinyqv_fetch_pkg;

  // Fetch stream state seen by the memory side
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_t;

  // Low two bits of a 32-bit RV32 instruction; anything else is a 16-bit RVC instruction
  localparam logic [1:0] RVC_MASK = 2'b11;

  // Instruction length in halfwords, decided from the low bits of its first halfword
  function automatic logic [1:0] instr_len_of(input logic [1:0] hw0);
    return (hw0 == RVC_MASK) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tinyqv_fetch_ring.sv
// rtl/tinyqv_fetch_ring.sv - halfword ring storage with wrap-bit read/write pointers
module tinyqv_fetch_ring #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [15:0]           wr_data,
  input  logic [1:0]            rd_adv,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic [15:0]           rd_hw0,
  output logic [15:0]           rd_hw1
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = PTR_W'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE    = DEPTH_LOG2'(1);

  logic [15:0]           slots [DEPTH];
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_idx0;
  logic [DEPTH_LOG2-1:0] rd_idx1;

  // The wrap bit makes full and empty distinguishable with plain subtraction
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LEVEL);
  assign rd_idx0 = rd_ptr[DEPTH_LOG2-1:0];
  assign rd_idx1 = rd_idx0 + IDX_ONE;
  assign rd_hw0  = slots[rd_idx0];
  assign rd_hw1  = slots[rd_idx1];

  // Slot storage is not reset; readers qualify it with level
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slots[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  // Pointer update; clear empties the ring on redirect
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_en);
      rd_ptr <= rd_ptr + PTR_W'(rd_adv);
    end
  end

endmodule

// File: rtl/tinyqv_fetch_buffer.sv
// rtl/tinyqv_fetch_buffer.sv - instruction prefetch buffer between QSPI fetch and decoder
module tinyqv_fetch_buffer
  import tinyqv_fetch_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int ADDR_HI    = 23
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_HI:1]    fetch_addr,
  output logic                fetch_restart,
  output logic                fetch_stall,
  input  logic                fetch_started,
  input  logic                fetch_stopped,
  input  logic [15:0]         fetch_data,
  input  logic                fetch_ready,
  output logic [31:0]         instr,
  output logic [1:0]          instr_len,
  output logic                instr_avail,
  output logic [ADDR_HI:1]    pc,
  input  logic                consume,
  input  logic                redirect,
  input  logic [ADDR_HI:1]    redirect_addr,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int LVL_W  = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] LVL_ONE     = LVL_W'(1);
  localparam logic [DEPTH_LOG2:0] LVL_TWO     = LVL_W'(2);
  localparam logic [DEPTH_LOG2:0] STALL_LEVEL = LVL_W'(DEPTH - 1);

  fetch_state_t        state;
  fetch_state_t        state_next;
  logic                full;
  logic [15:0]         rd_hw0;
  logic [15:0]         rd_hw1;
  logic                can_write;
  logic                write_en;
  logic                overflow_hit;
  logic                do_consume;
  logic [1:0]          consume_amt;
  logic [DEPTH_LOG2:0] level_next;
  logic                stall_next;

  tinyqv_fetch_ring #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clear   (redirect),
    .wr_en   (write_en),
    .wr_data (fetch_data),
    .rd_adv  (consume_amt),
    .level   (level),
    .full    (full),
    .rd_hw0  (rd_hw0),
    .rd_hw1  (rd_hw1)
  );

  // A whole instruction is present: one RVC halfword, or two halfwords of anything
  assign instr_avail = ((level >= LVL_ONE) && (rd_hw0[1:0] != RVC_MASK)) || (level >= LVL_TWO);
  assign instr       = instr_avail ? {rd_hw1, rd_hw0} : 32'h0;
  assign instr_len   = instr_len_of(instr[1:0]);

  // A same-cycle consume frees space before the write lands, so a full ring may still accept
  assign do_consume   = consume && instr_avail && !redirect;
  assign consume_amt  = do_consume ? instr_len : 2'b00;
  assign can_write    = !full || do_consume;
  assign write_en     = fetch_ready && (state == FS_RUN) && can_write && !redirect;
  assign overflow_hit = fetch_ready && (state == FS_RUN) && !can_write && !redirect;
  assign level_next   = redirect ? '0 : (level + LVL_W'(write_en) - LVL_W'(consume_amt));
  assign stall_next   = (state_next == FS_RUN) && (level_next >= STALL_LEVEL);
  assign fetch_restart = (state == FS_IDLE);

  // Next fetch state; redirect outranks everything, stopped outranks started
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FS_FLUSH;
    end else begin
      case (state)
        FS_IDLE:  if (!fetch_stopped && fetch_started) state_next = FS_RUN;
        FS_RUN:   if (fetch_stopped) state_next = FS_IDLE;
        FS_FLUSH: state_next = FS_IDLE;
        default:  state_next = FS_IDLE;
      endcase
    end
  end

  // Fetch FSM, addresses, registered stall and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FS_IDLE;
      pc          <= '0;
      fetch_addr  <= '0;
      fetch_stall <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      fetch_stall <= stall_next;
      if (overflow_hit) begin
        overflow <= 1'b1;
      end
      if (redirect) begin
        pc         <= redirect_addr;
        fetch_addr <= redirect_addr;
      end else begin
        if (do_consume) begin
          pc <= pc + ADDR_HI'(instr_len);
        end
        if (write_en) begin
          fetch_addr <= fetch_addr + ADDR_HI'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tinyqv_fetch_buffer.sv
// tb/tb_tinyqv_fetch_buffer.sv - directed self-checking bench for the prefetch buffer
module tb_tinyqv_fetch_buffer;

  localparam int DEPTH_LOG2 = 2;
  localparam int ADDR_HI    = 23;

  logic                clk = 1'b0;
  logic                rst;
  logic [ADDR_HI:1]    fetch_addr;
  logic                fetch_restart;
  logic                fetch_stall;
  logic                fetch_started;
  logic                fetch_stopped;
  logic [15:0]         fetch_data;
  logic                fetch_ready;
  logic [31:0]         instr;
  logic [1:0]          instr_len;
  logic                instr_avail;
  logic [ADDR_HI:1]    pc;
  logic                consume;
  logic                redirect;
  logic [ADDR_HI:1]    redirect_addr;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;

  int checks = 0;
  int errors = 0;

  tinyqv_fetch_buffer #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .ADDR_HI   (ADDR_HI)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_addr    (fetch_addr),
    .fetch_restart (fetch_restart),
    .fetch_stall   (fetch_stall),
    .fetch_started (fetch_started),
    .fetch_stopped (fetch_stopped),
    .fetch_data    (fetch_data),
    .fetch_ready   (fetch_ready),
    .instr         (instr),
    .instr_len     (instr_len),
    .instr_avail   (instr_avail),
    .pc            (pc),
    .consume       (consume),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .level         (level),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
    fetch_ready   = 1'b0;
    consume       = 1'b0;
    redirect      = 1'b0;
    fetch_started = 1'b0;
    fetch_stopped = 1'b0;
    rst           = 1'b0;
    #1;
  endtask

  task automatic push(input logic [15:0] hw);
    fetch_data  = hw;
    fetch_ready = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (pc !== 23'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (fetch_addr !== 23'h0) begin errors++; $display("FAIL reset_fetch_addr got %h want 0", fetch_addr); end
    checks++; if (instr_avail !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL reset_instr got avail=%b instr=%h want 0/0", instr_avail, instr); end
    checks++; if (overflow !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b stall=%b want 0/0", overflow, fetch_stall); end
    checks++; if (fetch_restart !== 1'b1) begin errors++; $display("FAIL reset_restart got %b want 1", fetch_restart); end
  endtask

  task automatic test_decode();
    fetch_started = 1'b1;
    cycle();
    checks++; if (fetch_restart !== 1'b0) begin errors++; $display("FAIL start_restart got %b want 0", fetch_restart); end
    push(16'h0013);
    checks++; if (instr_avail !== 1'b0) begin errors++; $display("FAIL half32_avail got %b want 0", instr_avail); end
    push(16'h0000);
    push(16'h4501);
    push(16'h8082);
    checks++; if (instr !== 32'h00000013 || instr_len !== 2'd2 || pc !== 23'd0) begin errors++; $display("FAIL first_instr got %h len %0d pc %h want 00000013 2 0", instr, instr_len, pc); end
    consume = 1'b1;
    cycle();
    checks++; if (instr[15:0] !== 16'h4501 || instr_len !== 2'd1 || pc !== 23'd2 || level !== 3'd2) begin errors++; $display("FAIL second_instr got %h len %0d pc %h lvl %0d want 4501 1 2 2", instr[15:0], instr_len, pc, level); end
    consume = 1'b1;
    cycle();
    checks++; if (instr[15:0] !== 16'h8082 || instr_len !== 2'd1 || pc !== 23'd3) begin errors++; $display("FAIL third_instr got %h len %0d pc %h want 8082 1 3", instr[15:0], instr_len, pc); end
    consume = 1'b1;
    cycle();
    checks++; if (instr_avail !== 1'b0 || instr !== 32'h0 || level !== 3'd0 || pc !== 23'd4) begin errors++; $display("FAIL drained got avail %b instr %h lvl %0d pc %h want 0 0 0 4", instr_avail, instr, level, pc); end
  endtask

  task automatic test_fill_overflow();
    push(16'h0001);
    push(16'h0001);
    checks++; if (fetch_stall !== 1'b0 || level !== 3'd2) begin errors++; $display("FAIL stall_lvl2 got stall %b lvl %0d want 0 2", fetch_stall, level); end
    push(16'h0001);
    checks++; if (fetch_stall !== 1'b1 || level !== 3'd3) begin errors++; $display("FAIL stall_lvl3 got stall %b lvl %0d want 1 3", fetch_stall, level); end
    push(16'h0001);
    checks++; if (level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got lvl %0d ovf %b want 4 0", level, overflow); end
    push(16'h0001);
    checks++; if (level !== 3'd4 || overflow !== 1'b1 || fetch_addr !== 23'd8) begin errors++; $display("FAIL overflow got lvl %0d ovf %b faddr %h want 4 1 8", level, overflow, fetch_addr); end
    cycle();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b want 1", overflow); end
  endtask

  task automatic test_redirect();
    rst = 1'b1;
    cycle();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_clears_ovf got %b want 0", overflow); end
    fetch_started = 1'b1;
    cycle();
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    fetch_data    = 16'h4444;
    fetch_ready   = 1'b1;
    consume       = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 23'h000101;
    cycle();
    checks++; if (level !== 3'd0 || pc !== 23'h000101 || fetch_addr !== 23'h000101) begin errors++; $display("FAIL redirect_state got lvl %0d pc %h faddr %h want 0 101 101", level, pc, fetch_addr); end
    checks++; if (fetch_restart !== 1'b0) begin errors++; $display("FAIL flush_restart got %b want 0", fetch_restart); end
    cycle();
    checks++; if (fetch_restart !== 1'b1) begin errors++; $display("FAIL idle_restart got %b want 1", fetch_restart); end
  endtask

  task automatic test_wrap_split();
    fetch_started = 1'b1;
    cycle();
    push(16'h0001);
    push(16'h0001);
    push(16'h0001);
    for (int i = 0; i < 3; i++) begin
      consume = 1'b1;
      cycle();
    end
    checks++; if (level !== 3'd0 || pc !== 23'h000104) begin errors++; $display("FAIL wrap_setup got lvl %0d pc %h want 0 104", level, pc); end
    push(16'h0093);
    cycle();
    checks++; if (instr_avail !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL split_wait got avail %b instr %h want 0 0", instr_avail, instr); end
    push(16'h0010);
    checks++; if (instr_avail !== 1'b1 || instr !== 32'h00100093 || instr_len !== 2'd2) begin errors++; $display("FAIL split_instr got avail %b instr %h len %0d want 1 00100093 2", instr_avail, instr, instr_len); end
  endtask

  task automatic test_back_to_back();
    push(16'h0001);
    push(16'h0001);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_full got lvl %0d want 4", level); end
    fetch_data  = 16'h0001;
    fetch_ready = 1'b1;
    consume     = 1'b1;
    cycle();
    checks++; if (level !== 3'd3 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_level got lvl %0d ovf %b want 3 0", level, overflow); end
    checks++; if (pc !== 23'h000106 || fetch_addr !== 23'h000109) begin errors++; $display("FAIL b2b_addr got pc %h faddr %h want 106 109", pc, fetch_addr); end
  endtask

  task automatic test_stop_and_reset();
    fetch_stopped = 1'b1;
    cycle();
    checks++; if (fetch_restart !== 1'b1 || level !== 3'd3 || instr_avail !== 1'b1) begin errors++; $display("FAIL stop_retain got restart %b lvl %0d avail %b want 1 3 1", fetch_restart, level, instr_avail); end
    push(16'h5555);
    checks++; if (level !== 3'd3 || fetch_addr !== 23'h000109) begin errors++; $display("FAIL idle_drop got lvl %0d faddr %h want 3 109", level, fetch_addr); end
    fetch_started = 1'b1;
    fetch_stopped = 1'b1;
    cycle();
    checks++; if (fetch_restart !== 1'b1) begin errors++; $display("FAIL stop_wins got restart %b want 1", fetch_restart); end
    fetch_started = 1'b1;
    cycle();
    push(16'h0001);
    rst = 1'b1;
    cycle();
    checks++; if (level !== 3'd0 || pc !== 23'd0 || fetch_addr !== 23'd0 || fetch_restart !== 1'b1 || instr_avail !== 1'b0) begin errors++; $display("FAIL mid_reset got lvl %0d pc %h faddr %h restart %b avail %b want 0 0 0 1 0", level, pc, fetch_addr, fetch_restart, instr_avail); end
  endtask

  initial begin
    rst           = 1'b1;
    fetch_started = 1'b0;
    fetch_stopped = 1'b0;
    fetch_data    = 16'h0;
    fetch_ready   = 1'b0;
    consume       = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_decode();
    test_fill_overflow();
    test_redirect();
    test_wrap_split();
    test_back_to_back();
    test_stop_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
